// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - button inputs and display outputs of the count sequencer
interface count_sequencer_if;
  logic       count_sequencer_btn_start;
  logic       count_sequencer_btn_clear;
  logic       count_sequencer_btn_lap;
  logic [3:0] count_sequencer_first_num;
  logic [3:0] count_sequencer_second_num;
  logic       count_sequencer_running;
  logic       count_sequencer_lap_active;
  logic       count_sequencer_wrap;

  modport master (
    output count_sequencer_btn_start,
    output count_sequencer_btn_clear,
    output count_sequencer_btn_lap,
    input  count_sequencer_first_num,
    input  count_sequencer_second_num,
    input  count_sequencer_running,
    input  count_sequencer_lap_active,
    input  count_sequencer_wrap
  );

  modport slave (
    input  count_sequencer_btn_start,
    input  count_sequencer_btn_clear,
    input  count_sequencer_btn_lap,
    output count_sequencer_first_num,
    output count_sequencer_second_num,
    output count_sequencer_running,
    output count_sequencer_lap_active,
    output count_sequencer_wrap
  );
endinterface

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - two-digit BCD stopwatch with start/stop, clear and lap freeze
module count_sequencer #(
  parameter int TICK_DIV  = 100000000,
  parameter int MAX_COUNT = 99
) (
  input  logic         count_sequencer_clk,
  input  logic         count_sequencer_rst_n,
  count_sequencer_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
  localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  logic [1:0]    rst_sync_q, rst_sync_d;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    prev_q, prev_d;
  logic [2:0]    evt_q, evt_d;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ones_q, ones_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    lap_ones_q, lap_ones_d;
  logic [3:0]    lap_tens_q, lap_tens_d;
  logic          wrap_q, wrap_d;

  logic       armed;
  logic       ev_start, ev_clear, ev_lap;
  logic       counting;
  logic       tick;
  logic       at_max;
  logic [2:0] btn_raw;

  assign btn_raw  = {bus.count_sequencer_btn_lap,
                     bus.count_sequencer_btn_clear,
                     bus.count_sequencer_btn_start};
  assign armed    = rst_sync_q[1];
  assign ev_start = evt_q[0];
  assign ev_clear = evt_q[1];
  assign ev_lap   = evt_q[2];
  assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);
  assign at_max   = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    // Until reset release has propagated, pretend every button was already
    // high so a button held through reset never looks like a fresh press.
    prev_d     = armed ? sync2_q : 3'b111;
    evt_d      = armed ? (sync2_q & ~prev_q) : 3'b000;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev_start)    state_d = ST_PAUSE;
        else if (ev_lap) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ev_start)    state_d = ST_PAUSE;
        else if (ev_lap) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ev_clear)      state_d = ST_IDLE;
        else if (ev_start) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d    = presc_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    lap_ones_d = lap_ones_q;
    lap_tens_d = lap_tens_q;
    wrap_d     = 1'b0;

    if ((state_q == ST_IDLE) || (state_d == ST_IDLE)) begin
      presc_d = '0;
    end else if (counting) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (state_d == ST_IDLE) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (tick) begin
      if (at_max) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        wrap_d = 1'b1;
      end else if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end

    // The frozen value is the count before any coincident tick.
    if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
      lap_ones_d = ones_q;
      lap_tens_d = tens_q;
    end
  end

  always_ff @(posedge count_sequencer_clk or negedge count_sequencer_rst_n) begin
    if (!count_sequencer_rst_n) begin
      rst_sync_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      evt_q      <= '0;
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      ones_q     <= '0;
      tens_q     <= '0;
      lap_ones_q <= '0;
      lap_tens_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      evt_q      <= evt_d;
      state_q    <= state_d;
      presc_q    <= presc_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      lap_ones_q <= lap_ones_d;
      lap_tens_q <= lap_tens_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.count_sequencer_first_num  = (state_q == ST_LAP) ? lap_ones_q : ones_q;
  assign bus.count_sequencer_second_num = (state_q == ST_LAP) ? lap_tens_q : tens_q;
  assign bus.count_sequencer_running    = counting;
  assign bus.count_sequencer_lap_active = (state_q == ST_LAP);
  assign bus.count_sequencer_wrap       = wrap_q;

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, is the number of clock cycles per count increment (1 s at 100 MHz); legal range 2..2^27.
REQ-002 Parameter MAX_COUNT, default 99, is the terminal decimal count value before wrap to 00; legal range 1..99.
REQ-003 count_sequencer_clk  input  1  system clock, 100 MHz; sole clock domain.
REQ-004 count_sequencer_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 count_sequencer_btn_start  input  1  start/stop button, asynchronous level.
REQ-006 count_sequencer_btn_clear  input  1  clear button, asynchronous level.
REQ-007 count_sequencer_btn_lap  input  1  lap (display freeze) button, asynchronous level.
REQ-008 count_sequencer_first_num  output  4  displayed ones digit, BCD 0..9.
REQ-009 count_sequencer_second_num  output  4  displayed tens digit, BCD 0..9.
REQ-010 count_sequencer_running  output  1  high in RUN and LAP.
REQ-011 count_sequencer_lap_active  output  1  high in LAP.
REQ-012 count_sequencer_wrap  output  1  one-cycle pulse on wrap MAX_COUNT -> 00.

Function
REQ-013 Each button shall pass a 2-flop synchronizer followed by a rising-edge detector; one event per press; event visible to the FSM 3 cycles after the pin rises (2 sync stages + edge register).
REQ-014 FSM states: IDLE, RUN, PAUSE, LAP; all state and output registers shall update on the rising clock edge.
REQ-015 Transitions: IDLE-start->RUN; RUN-start->PAUSE; RUN-lap->LAP; LAP-lap->RUN; LAP-start->PAUSE; PAUSE-start->RUN; PAUSE-clear->IDLE; IDLE-clear->IDLE; all other events ignored.
REQ-016 Clear in RUN or LAP shall be ignored.
REQ-017 Simultaneous events: clear beats start in PAUSE; start beats lap in RUN and LAP.
REQ-018 Prescaler counts 0..TICK_DIV-1 only in RUN and LAP; tick asserted the cycle it equals TICK_DIV-1, then returns to 0.
REQ-019 Prescaler holds in PAUSE; is 0 in IDLE; clears to 0 on IDLE->RUN.
REQ-020 On tick the live BCD count increments: ones 9->0 carries to tens.
REQ-021 On tick with live count == MAX_COUNT, count becomes 00 and count_sequencer_wrap pulses high for exactly that one cycle.
REQ-022 Entering IDLE shall set the live count to 00.
REQ-023 Outputs first_num/second_num show the live count in IDLE, RUN, PAUSE; in LAP they show the value latched on RUN->LAP.
REQ-024 Tick coincident with lap event: the latched value is the pre-increment count; the live count still increments.
REQ-025 On LAP->RUN or LAP->PAUSE the display shall show the live count from the next cycle.
REQ-026 Count continues advancing in LAP, including wrap and wrap pulse.

Reset
REQ-027 rst_n low shall asynchronously force: state IDLE, live and latched count 00, prescaler 0, synchronizer and edge registers 0, all outputs 0.
REQ-028 Reset deassertion shall be synchronized internally (2-flop); the FSM shall act on no event before the first clock edge after release.
REQ-029 A button held high through reset release shall not generate an event.
REQ-030 Reset asserted mid-count shall discard the count with no wrap pulse.

Verification (TICK_DIV=4, MAX_COUNT=99 unless stated)
REQ-031 Reset, start press -> running=1 on the 4th edge after the pin rises; digits 0,1 after 4 further cycles; 0,2 after 8.
REQ-032 Run to 99, one more tick -> digits 0,0, wrap=1 for one cycle; MAX_COUNT=15 variant: 15 -> 00 with wrap.
REQ-033 At count 23, lap press -> lap_active=1, digits frozen at 2,3 while live count advances; second lap press -> digits show live value (e.g. 2,7).
REQ-034 RUN at 05, clear press -> no change; start press -> PAUSE, digits hold 0,5 for 20 cycles; clear and start pressed together -> IDLE, digits 0,0, running=0.
REQ-035 Lap press aligned to tick at 41 -> latched digits 4,1; live count becomes 42.
REQ-036 rst_n pulled low for 1 ns mid-RUN at 37 -> all outputs 0 immediately; start held high across release -> state stays IDLE.
